// File: rtl/serial_word_adder_pkg.sv
// Shared definitions for serial_word_adder: FSM encodings and slice sizing helpers.
package serial_word_adder_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    function automatic int swa_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice build still needs a 1-bit index register.
    function automatic int swa_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/serial_word_adder_chunk_add.sv
// Combinational CHUNK-bit adder slice; cmsb is the carry into the slice MSB.
module chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];
    // The MSB sum bit is a^b^carry_in, so the carry in is recovered from it.
    assign cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/serial_word_adder.sv
// Multi-cycle add/subtract, one CHUNK-bit slice per clock, LSB first.
// Define SWA_OVF_EN to add the signed-overflow output ovf.
module serial_word_adder
    import serial_word_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SWA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = swa_nchunk(WIDTH, CHUNK);
    localparam int IW     = swa_idx_w(NCHUNK);

    logic [ST_W-1:0]  state;
    logic [WIDTH-1:0] wa, wb, ws, ws_nxt;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_co, last;
`ifdef SWA_OVF_EN
    logic             sl_cm;
`endif

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign last = (idx == IW'(NCHUNK - 1));

    assign sl_a = wa[int'(idx)*CHUNK +: CHUNK];
    assign sl_b = wb[int'(idx)*CHUNK +: CHUNK];

    chunk_add #(.CHUNK(CHUNK)) u_chunk (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .sum  (sl_s),
        .cout (sl_co),
`ifdef SWA_OVF_EN
        .cmsb (sl_cm)
`else
        .cmsb ()
`endif
    );

    // The final slice is merged here so completion can publish the full word in one edge.
    always_comb begin
        ws_nxt = ws;
        ws_nxt[int'(idx)*CHUNK +: CHUNK] = sl_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            wa    <= '0;
            wb    <= '0;
            ws    <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SWA_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    ws    <= ws_nxt;
                    carry <= sl_co;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        state <= ST_DONE;
                        idx   <= '0;
                        sum   <= ws_nxt;
                        cout  <= sl_co;
`ifdef SWA_OVF_EN
                        ovf   <= sl_co ^ sl_cm;
`endif
                    end
                end
                default: begin
                    // IDLE and DONE both accept; subtraction is a + ~b + 1.
                    if (start) begin
                        state <= ST_RUN;
                        wa    <= a;
                        wb    <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        idx   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_adder.sv
// Scoreboard bench for serial_word_adder: 32/8 and 8/8 instances, directed vectors.
module tb_serial_word_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;
    logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
`ifdef SWA_OVF_EN
    logic        ovf32, ovf8;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q32[$];
    exp_t q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_word_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
`ifdef SWA_OVF_EN
        , .ovf(ovf32)
`endif
    );

    serial_word_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SWA_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per done pulse and compare result and latency.
    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            chk("done32_expected", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                chk("sum32", sum32, e.sum);
                chk("cout32", 32'(cout32), 32'(e.cout));
                chk("latency32", 32'(cyc), 32'(e.cyc));
`ifdef SWA_OVF_EN
                chk("ovf32", 32'(ovf32), 32'(e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            chk("done8_expected", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("sum8", 32'(sum8), 32'(e.sum[7:0]));
                chk("cout8", 32'(cout8), 32'(e.cout));
                chk("latency8", 32'(cyc), 32'(e.cyc));
`ifdef SWA_OVF_EN
                chk("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic drain(input string nm);
        for (int k = 0; k < 40 && (q32.size() != 0 || q8.size() != 0); k++) @(negedge clk);
        chk({nm, "_drained"}, 32'(q32.size() + q8.size()), 32'd0);
        q32.delete();
        q8.delete();
    endtask

    // One 32-bit operation; optionally pulses start with junk operands mid-RUN.
    task automatic op32(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic is, input logic [31:0] es,
                        input logic ec, input logic eo, input bit pulse);
        int nb = 0;
        exp_t e;
        @(negedge clk);
        a32 = ia; b32 = ib; cin32 = ic; sub32 = is; start32 = 1'b1;
        @(posedge clk); #1;
        e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 4;
        q32.push_back(e);
        @(negedge clk);
        start32 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done32) break;
            if (busy32) nb++;
            if (pulse && k == 1) begin
                start32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h0F0F_0F0F; sub32 = 1'b1;
            end else begin
                start32 = 1'b0;
            end
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, 32'(done32), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(nb), 32'd4);
        chk({nm, "_busy_at_done"}, 32'(busy32), 32'd0);
        drain(nm);
    endtask

    initial begin
        int acc1, acc2;
        exp_t e;
        repeat (3) @(negedge clk);
        chk("rst_sum", sum32, 32'd0);
        chk("rst_cout", 32'(cout32), 32'd0);
        chk("rst_busy", 32'(busy32), 32'd0);
        chk("rst_done", 32'(done32), 32'd0);
        rst = 1'b0;

        op32("add",      32'd10,         32'd32, 1'b0, 1'b0, 32'd42,         1'b0, 1'b0, 1'b0);
        op32("ripple",   32'hFFFF_FFFF,  32'd1,  1'b0, 1'b0, 32'h0000_0000,  1'b1, 1'b0, 1'b0);
        op32("sub",      32'd5,          32'd7,  1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0);
        op32("sub_brw",  32'd5,          32'd7,  1'b1, 1'b1, 32'hFFFF_FFFD,  1'b0, 1'b0, 1'b0);
        op32("sub_pos",  32'd7,          32'd5,  1'b0, 1'b1, 32'd2,          1'b1, 1'b0, 1'b0);
        op32("ovf_pos",  32'h7FFF_FFFF,  32'd1,  1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0);
        op32("ovf_neg",  32'h8000_0000,  32'd1,  1'b0, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0);
        op32("run_pulse", 32'd3,         32'd4,  1'b0, 1'b0, 32'd7,          1'b0, 1'b0, 1'b1);

        // Reset during the second RUN cycle: no done, outputs cleared.
        @(negedge clk);
        a32 = 32'd1; b32 = 32'd2; cin32 = 1'b0; sub32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sum", sum32, 32'd0);
        chk("abort_cout", 32'(cout32), 32'd0);
        chk("abort_busy", 32'(busy32), 32'd0);
        chk("abort_done", 32'(done32), 32'd0);
`ifdef SWA_OVF_EN
        chk("abort_ovf", 32'(ovf32), 32'd0);
`endif
        rst = 1'b0;
        repeat (6) @(negedge clk);

        op32("after_rst", 32'd64, 32'd64, 1'b0, 1'b0, 32'd128, 1'b0, 1'b0, 1'b0);

        // Back-to-back 32-bit: start held, second accept lands in the DONE cycle.
        @(negedge clk);
        a32 = 32'd100; b32 = 32'd23; cin32 = 1'b1; sub32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        acc1 = cyc;
        e.sum = 32'd124; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = acc1 + 4;
        q32.push_back(e);
        @(negedge clk);
        a32 = 32'h0000_0100; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b1;
        for (int k = 0; k < 20 && !done32; k++) @(negedge clk);
        @(posedge clk); #1;
        acc2 = cyc;
        e.sum = 32'h0000_00FF; e.cout = 1'b1; e.ovf = 1'b0; e.cyc = acc2 + 4;
        q32.push_back(e);
        chk("b2b_gap", 32'(acc2 - acc1), 32'd5);
        @(negedge clk);
        start32 = 1'b0;
        drain("b2b32");

        // 8-bit single slice with start held: accept every DONE cycle.
        @(negedge clk);
        a8 = 8'd255; b8 = 8'd1; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        acc1 = cyc;
        for (int k = 0; k < 3; k++) begin
            e.sum = 32'd0; e.cout = 1'b1; e.ovf = 1'b0; e.cyc = acc1 + 1 + 2 * k;
            q8.push_back(e);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        drain("held8");

        // 8-bit signed overflow, single op.
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        e.sum = 32'h80; e.cout = 1'b0; e.ovf = 1'b1; e.cyc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        drain("ovf8");
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_word_adder.md
# serial_word_adder

Multi-cycle, parametrised adder/subtractor that processes WIDTH-bit operands one CHUNK-bit slice per clock, carrying between slices in a register. It is the sequential successor to the single-byte combinational adder. It suits datapaths where a full-width ripple adder would miss timing or cost too much area. A start/busy/done handshake lets a controller or bench issue back-to-back operations.

## Interface
- WIDTH, 32: operand/result width; must be a positive multiple of CHUNK.
- CHUNK, 8: slice width added per cycle. NCHUNK = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in (borrow-in when sub=1); captured on accepted start.
- sub  input  1  0 = add, 1 = subtract; captured on accepted start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry out of MSB (sub=1: 1 = no borrow).
- ovf  output  1  signed overflow; present only with SWA_OVF_EN.

## Operation
- Result = a + (sub ? ~b : b) + (cin ^ sub), modulo 2^WIDTH.
  - sub=1, cin=0 gives a−b.
  - sub=1, cin=1 gives a−b−1.
- States:
  - IDLE: wait for start.
  - RUN: process slices, slice index idx = 0..NCHUNK-1.
  - DONE: one cycle.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE after slice NCHUNK-1.
  - DONE→RUN on start, else DONE→IDLE.
- On accept:
  - Latch a into the working A register and the effective B into the working B register.
  - Carry register ← cin ^ sub; idx ← 0.
- Each RUN cycle:
  - Add slice idx of A and B plus the carry register.
  - Write the CHUNK-bit result into slice idx of the working sum.
  - Carry register ← slice carry-out; idx increments.
- On the final slice:
  - Copy the working sum to sum and the final carry to cout.
  - Compute ovf from the final slice.
- start during RUN is ignored. Operand inputs are don't-care except in the accept cycle.
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, idx 0, carry register 0.
- Reset mid-RUN aborts the operation: no done pulse, and all outputs return to their reset values.
- rst has priority over start.

## Timing
- Accept edge E0: start=1 sampled in IDLE or DONE. busy=1 from E0 onward.
- Edges E1..E_NCHUNK process slices 0..NCHUNK-1, LSB first.
- After E_NCHUNK:
  - busy=0, done=1 for exactly one cycle.
  - sum, cout and ovf are already updated.
- Latency: NCHUNK cycles from accept to done.
- Throughput: one operation per NCHUNK+1 cycles, with start held high or reasserted in the DONE cycle.
- NCHUNK=1: done is high in the cycle after E1; the block behaves as a registered single-slice adder.
- sum, cout and ovf never change except at completion or reset; no partial results are visible.

## Configuration
- SWA_OVF_EN defined:
  - The ovf port exists.
  - ovf = carry into MSB XOR carry out of MSB, i.e. the operands' sign bits agree and differ from the result sign.
  - ovf updates at completion alongside cout.
- SWA_OVF_EN undefined: no ovf port and no overflow logic. All other behaviour is identical.

## Structure
- Shared package or header holds the state encodings (IDLE, RUN, DONE), the state width, and a helper that computes NCHUNK and idx width, clog2(NCHUNK) with a minimum of 1.
- One sub-module, chunk_add: combinational CHUNK-bit adder with inputs a, b, cin and outputs sum, cout, plus the MSB carry-in used for ovf.
  - Instantiate it once and multiplex the slice inputs by idx.

## Test plan
- Add, WIDTH=32/CHUNK=8: a=10, b=32, cin=0, sub=0 → done exactly 4 cycles after the accept edge; sum=42, cout=0, busy high for 4 cycles.
- Full carry ripple: a=0xFFFFFFFF, b=1 → sum=0x00000000, cout=1, ovf=0.
- Subtract: a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0. With cin=1 → sum=0xFFFFFFFD.
- Overflow (SWA_OVF_EN): a=0x7FFFFFFF, b=1 → sum=0x80000000, ovf=1, cout=0. Build without the macro → no ovf port, same sum.
- Handshake and reset:
  - start pulsed during RUN → ignored, result unchanged.
  - rst at the 2nd RUN cycle → no done; outputs are 0 next cycle.
  - A following start with a=64, b=64 → sum=128.
- WIDTH=8/CHUNK=8: a=255, b=1 → done one cycle after accept; sum=0, cout=1. Start held high → a new accept occurs in every DONE cycle.
